// File: rtl/alu_issue_wb.sv
// -----------------------------------------------------------------------------
// alu_issue_wb
//
// Issue/writeback stage around an external combinational ALU. It takes one
// command at a time and runs it through three phases:
//   IDLE  accept a command and read its operands from the register file
//   EXEC  drive the ALU from registered operands, then write back its result
//   RESP  hold the result on the response port until the consumer takes it
//
// Ports
//   clk, rst              single clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                ALU operation select
//   cmd_rd                destination register
//   cmd_rs1, cmd_rs2      source registers for ALU A and ALU B
//   cmd_imm_en, cmd_imm   use the immediate instead of rf[cmd_rs2] for ALU B
//   alu_a/alu_b/alu_sel   registered operands and select driven to the ALU
//   alu_out, alu_carry,
//   alu_zero, alu_neg,
//   alu_ovf               ALU result and flags
//   res_valid/res_ready   result handshake (valid only in RESP)
//   res_data, res_flags   captured result and flags {C,Z,N,V}
//   flags                 architectural status register {C,Z,N,V}
//   dbg_addr, dbg_rdata   combinational register-file debug read port
// -----------------------------------------------------------------------------
module alu_issue_wb #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 4,
  parameter int SEL_W  = 4,
  localparam int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_flags,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [REG_N];
  logic [DATA_W-1:0]   rf_d [REG_N];
  logic [SEL_W-1:0]    op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [3:0]          res_flags_q, res_flags_d;
  logic                accept;
  logic [3:0]          alu_flags;

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign alu_flags = {alu_carry, alu_zero, alu_neg, alu_ovf};

  // The ALU sees only registered values, and they are held outside EXEC so
  // its inputs never glitch between commands.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = op_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign flags     = flags_q;
  assign dbg_rdata = rf_q[dbg_addr];

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    op_d        = op_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Operands are read here; the previous writeback has already
          // landed, so no forwarding is needed.
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          a_d     = rf_q[cmd_rs1];
          b_d     = cmd_imm_en ? cmd_imm : rf_q[cmd_rs2];
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Writeback is unconditional; backpressure only delays the next command.
        rf_d[rd_q]  = alu_out;
        flags_d     = alu_flags;
        res_data_d  = alu_out;
        res_flags_d = alu_flags;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset during EXEC drops the pending writeback entirely.
      state_q     <= IDLE;
      for (int i = 0; i < REG_N; i++) begin
        rf_q[i] <= '0;
      end
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      flags_q     <= flags_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_wb
//
// Bench for alu_issue_wb. A small behavioural ALU drives the stage's ALU
// inputs. The reference model keeps the register file and status flags as
// plain arrays, computes each command's result when the command is issued, and
// queues the expected response. A compare process checks the response port,
// flags and the debug read port on every cycle where they are meaningful.
// -----------------------------------------------------------------------------
module tb_alu_issue_wb;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry, alu_zero, alu_neg, alu_ovf;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic [3:0] flags;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  rf_m [4];
  logic [3:0]  flags_m;
  logic [11:0] exp_q [$];
  logic        mon_en;
  logic [11:0] got;

  alu_issue_wb #(.DATA_W(8), .REG_N(4), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .alu_ovf    (alu_ovf),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {result[7:0], C, Z, N, V}
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {r, c, (r == 8'h00), r[7], v};
  endfunction

  assign {alu_out, alu_carry, alu_zero, alu_neg, alu_ovf} = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
    flags_m = 4'h0;
    exp_q.delete();
  endtask

  // Compare process: response port while valid, flags and debug port outside EXEC.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("ready_valid_exclusive", {31'b0, cmd_ready && res_valid}, 32'd0);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", {31'b0, res_valid}, 32'd0);
        end else begin
          chk("res_data", {24'b0, res_data}, {24'b0, exp_q[0][11:4]});
          chk("res_flags", {28'b0, res_flags}, {28'b0, exp_q[0][3:0]});
        end
      end
      if (cmd_ready || res_valid) begin
        chk("flags", {28'b0, flags}, {28'b0, flags_m});
        chk("dbg_rdata", {24'b0, dbg_rdata}, {24'b0, rf_m[dbg_addr]});
      end
    end
  end

  always @(posedge clk) begin
    if (mon_en && !rst && res_valid && res_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      #1 dbg_addr = 2'($urandom);
    end
  end

  // One full command: accept, EXEC, optional stall in RESP, handshake.
  // Returns at the falling edge of the first IDLE cycle after the handshake.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                       input int stall, input logic pend);
    logic [7:0]  a, b;
    logic [11:0] r;
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    a = rf_m[rs1];
    b = ie ? imm : rf_m[rs2];
    r = alu_f(op, a, b);
    exp_q.push_back(r);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = ie; cmd_imm = imm;
    res_ready = (stall == 0);
    @(negedge clk);
    // EXEC: a held or stray command must be ignored from here on
    cmd_valid = pend;
    cmd_op = 4'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm_en = 1'($urandom); cmd_imm = 8'($urandom);
    chk("exec_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("exec_res_valid", {31'b0, res_valid}, 32'd0);
    chk("exec_alu_a", {24'b0, alu_a}, {24'b0, a});
    chk("exec_alu_b", {24'b0, alu_b}, {24'b0, b});
    chk("exec_alu_sel", {28'b0, alu_sel}, {28'b0, op});
    rf_m[rd] = r[11:4];
    flags_m  = r[3:0];
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
      chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("stall_alu_a", {24'b0, alu_a}, {24'b0, a});
      @(negedge clk);
    end
    res_ready = 1'b1;
    chk("resp_valid", {31'b0, res_valid}, 32'd1);
    got = {res_data, res_flags};
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("post_res_valid", {31'b0, res_valid}, 32'd0);
    chk("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_alu_a", {24'b0, alu_a}, {24'b0, a});
    chk("post_alu_b", {24'b0, alu_b}, {24'b0, b});
    chk("post_alu_sel", {28'b0, alu_sel}, {28'b0, op});
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk({tag, "_dbg"}, {24'b0, dbg_rdata}, 32'd0);
    end
    chk({tag, "_flags"}, {28'b0, flags}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mon_en = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; res_ready = 1'b1; dbg_addr = '0;
    model_reset();

    // 1. reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_alu_a", {24'b0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'b0, alu_b}, 32'd0);
    chk("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
    check_all_zero("rst");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 2. r0 = 0 + F9
    issue(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'hF9, 0, 1'b0);
    chk("t2_res", {20'b0, got}, {20'b0, 8'hF9, 4'b0010});
    dbg_addr = 2'd0; #1;
    chk("t2_dbg_r0", {24'b0, dbg_rdata}, 32'h0000_00F9);

    // 3. r1 = r0 + 0A (carry)
    issue(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0A, 0, 1'b0);
    chk("t3_res", {20'b0, got}, {20'b0, 8'h03, 4'b1000});
    chk("t3_flags", {28'b0, flags}, 32'h8);
    dbg_addr = 2'd1; #1;
    chk("t3_dbg_r1", {24'b0, dbg_rdata}, 32'h0000_0003);

    // 4. back-to-back dependency r2 = r1 + r1
    issue(4'd0, 2'd2, 2'd1, 2'd1, 1'b0, 8'h55, 0, 1'b0);
    chk("t4_res", {20'b0, got}, {20'b0, 8'h06, 4'b0000});
    chk("t4_flags", {28'b0, flags}, 32'h0);

    // 5. backpressure r3 = r0 + 07 with a stray command pending
    issue(4'd0, 2'd3, 2'd0, 2'd0, 1'b1, 8'h07, 5, 1'b1);
    chk("t5_res", {20'b0, got}, {20'b0, 8'h00, 4'b1100});
    dbg_addr = 2'd3; #1;
    chk("t5_dbg_r3", {24'b0, dbg_rdata}, 32'h0000_0000);
    dbg_addr = 2'd0; #1;
    chk("t5_dbg_r0", {24'b0, dbg_rdata}, 32'h0000_00F9);

    // 6. reset in EXEC of r1 = r0 + 01
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'h01;
    chk("t6_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("t6_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("t6_res_valid_after", {31'b0, res_valid}, 32'd0);
    check_all_zero("t6");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_res_valid", {31'b0, res_valid}, 32'd0);
    end
    mon_en = 1'b1;

    // Random commands with random backpressure and stray pending commands
    for (int k = 0; k < 150; k++) begin
      issue(4'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
